// File: rtl/riscv_crypto_sha256_msched.sv
// SHA-256 message-schedule sequencer: loads W0..W15, streams W0..W63.
// One shared sigma unit is used for sig0 (CALC0) and then sig1 (CALC1).

module riscv_crypto_fu_ssha256 (
  input  logic        op_ssha256_sig0,
  input  logic        op_ssha256_sig1,
  input  logic        op_ssha256_sum0,
  input  logic        op_ssha256_sum1,
  input  logic [31:0] rs1,
  output logic [31:0] rd
);
  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  logic [31:0] sig0, sig1, sum0, sum1;

  always_comb begin
    sig0 = ror(rs1, 7)  ^ ror(rs1, 18) ^ (rs1 >> 3);
    sig1 = ror(rs1, 17) ^ ror(rs1, 19) ^ (rs1 >> 10);
    sum0 = ror(rs1, 2)  ^ ror(rs1, 13) ^ ror(rs1, 22);
    sum1 = ror(rs1, 6)  ^ ror(rs1, 11) ^ ror(rs1, 25);
    rd = ({32{op_ssha256_sig0}} & sig0) | ({32{op_ssha256_sig1}} & sig1) |
         ({32{op_ssha256_sum0}} & sum0) | ({32{op_ssha256_sum1}} & sum1);
  end
endmodule

module riscv_crypto_sha256_msched (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_idx,
  output logic        out_last,
  output logic        busy
);
  typedef enum logic [1:0] {S_LOAD, S_EMIT, S_CALC0, S_CALC1} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] s0_q, s0_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, in_ready_q, busy_q, out_last_q;

  logic [31:0] wbuf_q [16];
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;

  logic        fu_sig0, fu_sig1;
  logic [31:0] fu_rs1, fu_rd;
  logic [3:0]  t_lo, t_nx, t_m15, t_m7, t_m2;
  logic [31:0] w_new;

  riscv_crypto_fu_ssha256 u_fu (
    .op_ssha256_sig0 (fu_sig0),
    .op_ssha256_sig1 (fu_sig1),
    .op_ssha256_sum0 (1'b0),
    .op_ssha256_sum1 (1'b0),
    .rs1             (fu_rs1),
    .rd              (fu_rd)
  );

  // Circular-buffer taps relative to t; 4-bit wrap does the mod 16.
  always_comb begin
    t_lo  = t_q[3:0];
    t_nx  = t_lo + 4'd1;
    t_m15 = t_lo - 4'd15;
    t_m7  = t_lo - 4'd7;
    t_m2  = t_lo - 4'd2;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    t_d        = t_q;
    s0_d       = s0_q;
    out_data_d = out_data_q;
    wr_en      = 1'b0;
    wr_addr    = cnt_q[3:0];
    wr_data    = in_data;
    fu_sig0    = 1'b0;
    fu_sig1    = 1'b0;
    fu_rs1     = 32'd0;
    w_new      = 32'd0;
    unique case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            t_d        = 6'd0;
            out_data_d = wbuf_q[0];
            state_d    = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          t_d = t_q + 6'd1;
          if (t_q < 6'd15) begin
            out_data_d = wbuf_q[t_nx];
          end else if (t_q == 6'd63) begin
            cnt_d   = 5'd0;
            state_d = S_LOAD;
          end else begin
            state_d = S_CALC0;
          end
        end
      end
      S_CALC0: begin
        fu_sig0 = 1'b1;
        fu_rs1  = wbuf_q[t_m15];
        s0_d    = fu_rd;
        state_d = S_CALC1;
      end
      S_CALC1: begin
        fu_sig1    = 1'b1;
        fu_rs1     = wbuf_q[t_m2];
        // wbuf[t] still holds W[t-16] until this write lands.
        w_new      = fu_rd + wbuf_q[t_m7] + s0_q + wbuf_q[t_lo];
        wr_en      = 1'b1;
        wr_addr    = t_lo;
        wr_data    = w_new;
        out_data_d = w_new;
        state_d    = S_EMIT;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      cnt_q       <= 5'd0;
      t_q         <= 6'd0;
      s0_q        <= 32'd0;
      out_data_q  <= 32'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      t_q         <= t_d;
      s0_q        <= s0_d;
      out_data_q  <= out_data_d;
      out_valid_q <= (state_d == S_EMIT);
      in_ready_q  <= (state_d == S_LOAD);
      busy_q      <= (state_d != S_LOAD);
      out_last_q  <= (state_d == S_EMIT) && (t_d == 6'd63);
    end
  end

  // Buffer is never read before written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) wbuf_q[wr_addr] <= wr_data;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = t_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_riscv_crypto_sha256_msched.sv
// Directed bench for the SHA-256 message-schedule sequencer.
module tb_riscv_crypto_sha256_msched;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_idx;
  logic        out_last;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] blk   [16];
  logic [31:0] expw  [64];
  logic [31:0] got_w [64];
  int          load_cyc, drain_cyc;

  riscv_crypto_sha256_msched dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic gen_exp();
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) expw[i] = blk[i];
    for (int i = 16; i < 64; i++) begin
      a = rr(expw[i-15], 7) ^ rr(expw[i-15], 18) ^ (expw[i-15] >> 3);
      b = rr(expw[i-2], 17) ^ rr(expw[i-2], 19) ^ (expw[i-2] >> 10);
      expw[i] = b + expw[i-7] + a + expw[i-16];
    end
  endtask

  task automatic load_block(input bit gaps);
    int cnt = 0;
    load_cyc = 0;
    while (cnt < 16 && load_cyc < 2000) begin
      @(negedge clk);
      chk("load_busy", {31'd0, busy}, 32'd0);
      if (gaps && ($urandom % 4 == 0)) begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end else begin
        in_valid = 1'b1;
        in_data  = blk[cnt];
      end
      if (in_valid && in_ready) cnt++;
      @(posedge clk);
      load_cyc++;
    end
    if (cnt < 16) chk("load_timeout", cnt, 16);
  endtask

  task automatic drain(input bit bp, input int abort_idx);
    int got = 0;
    bit stall = 1'b0;
    bit done  = 1'b0;
    logic [31:0] pdata;
    logic [5:0]  pidx;
    drain_cyc = 0;
    while (!done && got < 64 && drain_cyc < 5000) begin
      @(negedge clk);
      in_valid = bp ? ($urandom % 2 == 0) : 1'b0;
      in_data  = $urandom;
      chk("emit_in_ready", {31'd0, in_ready}, 32'd0);
      chk("emit_busy", {31'd0, busy}, 32'd1);
      if (stall) begin
        chk("stall_data", out_data, pdata);
        chk("stall_idx", {26'd0, out_idx}, {26'd0, pidx});
      end
      if (out_valid && got == abort_idx) begin
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_idx", {26'd0, out_idx}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        done = 1'b1;
      end else begin
        out_ready = bp ? ($urandom % 3 != 0) : 1'b1;
        if (out_valid && out_ready) begin
          got_w[got] = out_data;
          chk($sformatf("word%0d", got), out_data, expw[got]);
          chk("idx", {26'd0, out_idx}, got);
          chk("last", {31'd0, out_last}, {31'd0, got == 63});
          got++;
        end
        stall = out_valid && !out_ready;
        pdata = out_data;
        pidx  = out_idx;
        @(posedge clk);
        drain_cyc++;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      if (got < 64) chk("drain_timeout", got, 64);
      @(negedge clk);
      out_ready = 1'b0;
      chk("post_in_ready", {31'd0, in_ready}, 32'd1);
      chk("post_busy", {31'd0, busy}, 32'd0);
      chk("post_out_valid", {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_idx", {26'd0, out_idx}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // "abc" padded block, full throughput
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0] = 32'h61626380; blk[15] = 32'h00000018;
    gen_exp();
    load_block(1'b0);
    drain(1'b0, -1);
    chk("abc_w16", got_w[16], 32'h61626380);
    chk("abc_w17", got_w[17], 32'h000F0000);
    chk("abc_cycles", load_cyc + drain_cyc, 176);

    // sigma0 path only
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[1] = 32'h00000001;
    gen_exp();
    load_block(1'b0);
    drain(1'b0, -1);
    chk("sig0_w16", got_w[16], 32'h02004000);

    // all-zero block
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    gen_exp();
    load_block(1'b0);
    drain(1'b0, -1);
    chk("zero_w63", got_w[63], 32'd0);

    // random blocks with backpressure and input gaps
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      gen_exp();
      load_block(1'b1);
      drain(1'b1, -1);
    end

    // back-to-back random blocks
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      gen_exp();
      load_block(1'b0);
      drain(1'b0, -1);
    end

    // mid-stream reset at idx 30, then a fresh block
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    gen_exp();
    load_block(1'b0);
    drain(1'b0, 30);
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    gen_exp();
    load_block(1'b0);
    drain(1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
